debug_dump_engine: RTL and testbench
====================================

Name: debug_dump_engine

Overview:
- Parametrised successor to the fixed-format debug frame sender that sits between the MIPS pipeline and the UART transmitter in the debug path.
- On a start pulse it latches the PC and the cycle counter, then reads N_REGS registers and scans every data-memory word. Each memory word is read through a 1-cycle-latency port.
- It streams a byte-framed dump to the UART TX. Dump content is selectable by mode, and only dirty memory words are emitted.

Parameters:
- NB_DATA, 32, width of PC, register and memory words; must be a multiple of 8.
- NB_CYCLES, 8, cycle counter width; must be a multiple of 8.
- NB_REG, 5, register address width.
- N_REGS, 32, number of registers dumped (1..2**NB_REG).
- NB_ADDR, 7, data memory address width; sent as one byte when ≤8, otherwise as ceil(NB_ADDR/8) bytes, MSB first.
- MEM_DEPTH, 128, number of memory words scanned (≤2**NB_ADDR).
- HEADER, 8'hA5, frame start byte.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle dump request
- mode_i  in  2  00 full, 01 regs only, 10 mem only, 11 PC+cycles only; sampled with start_i
- pc_i  in  NB_DATA  current PC
- cycles_i  in  NB_CYCLES  cycle count
- reg_addr_o  out  NB_REG  register read address
- reg_rd_o  out  1  register read strobe
- reg_data_i  in  NB_DATA  register data, valid 1 cycle after reg_rd_o
- mem_addr_o  out  NB_ADDR  memory read address
- mem_rd_o  out  1  memory read strobe
- mem_data_i  in  NB_DATA  memory data, valid 1 cycle after mem_rd_o
- mem_dirty_i  in  1  dirty bit of addressed word, valid together with mem_data_i
- tx_data_o  out  8  byte to transmit
- tx_start_o  out  1  one-cycle transmit request
- tx_done_i  in  1  UART byte-complete pulse
- busy_o  out  1  high from the cycle after start_i is accepted until DONE
- end_send_data_o  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (reset_i=0 at a clock edge): state IDLE. All outputs are 0, all counters 0, checksum 0. A reset mid-frame aborts the frame immediately; there is no partial completion and no end pulse.
- IDLE: start_i=1 latches pc_i, cycles_i and mode_i, then goes to HDR. start_i while busy is ignored.
- Byte send primitive: load tx_data_o, assert tx_start_o for exactly 1 cycle, then WAIT until tx_done_i. tx_data_o is held stable throughout WAIT. tx_done_i outside WAIT is ignored.
- Frame order: HEADER, PC bytes, cycle bytes, register section, memory section, terminator, checksum (optional). All multi-byte fields are sent MSB first.
- Mode gating:
  - PC and cycles are sent in every mode.
  - Register section is sent in modes 00 and 01.
  - Memory section is sent in modes 00 and 10.
- Register section:
  - REG_REQ: drive reg_addr_o=i and reg_rd_o=1 for 1 cycle.
  - REG_CAP: capture reg_data_i.
  - Send NB_DATA/8 bytes, then i++ until i=N_REGS-1.
- Memory section:
  - MEM_REQ: drive mem_addr_o=a and mem_rd_o=1 for 1 cycle.
  - MEM_CAP: capture data and dirty bit.
  - If dirty: send tag 8'h01, the address byte(s), then the data bytes.
  - If clean: no bytes are sent; a goes to a+1 (2 cycles per clean word).
  - After a=MEM_DEPTH-1, send terminator tag 8'h00. The terminator is sent even if there are 0 dirty words. It is not sent when the memory section is skipped.
- DONE: pulse end_send_data_o for 1 cycle, deassert busy_o, return to IDLE. start_i on the DONE cycle is ignored.
- Simultaneous events: tx_done_i arriving in the same cycle as tx_start_o is not a completion; only a tx_done_i seen in WAIT advances the state.
- Counters are sized to hold N_REGS-1 and MEM_DEPTH-1 without wrap. Address outputs are zero-extended.

Optional Feature:
- Macro DEBUG_DUMP_CHECKSUM_EN.
- Defined: an 8-bit XOR of every byte sent after HEADER (including the terminator) is appended as the final byte before DONE. The XOR accumulator is cleared on start_i acceptance.
- Undefined: no checksum byte is sent and no accumulator logic exists; DONE follows the last section directly.

Test Plan:
- Mode 11, pc_i=32'h0000_0040, cycles_i=8'h07, tx_done_i 3 cycles after each start → bytes A5 00 00 00 40 07 (plus checksum 47 with the macro), then one end_send_data_o pulse, busy_o back to 0.
- Mode 01, N_REGS=2, reg0=32'h1, reg1=32'hDEADBEEF → after PC/cycles: 00 00 00 01 DE AD BE EF. No memory tag is sent and no terminator is sent.
- Mode 10, MEM_DEPTH=4, only addr 2 dirty with 32'h12345678 → 01 02 12 34 56 78 00; clean addresses add no bytes.
- Mode 00 with all memory clean → register bytes followed by a single 00 terminator; end pulse exactly once.
- Reset driven low during register byte 3 → next cycle tx_start_o=0, busy_o=0, no end pulse. A new start_i then produces a full frame beginning with A5.
- start_i re-pulsed while busy, plus a stray tx_done_i in IDLE → frame unchanged, no extra frame or byte emitted.

Source files
------------

// File: rtl/debug_dump_engine_if.sv
// rtl/debug_dump_engine_if.sv - handshake and bus bundle for the debug dump engine
// Purpose: groups every non-clock/reset signal of debug_dump_engine.
// Ports (engine view, modport slave):
//   start_i/mode_i/pc_i/cycles_i      dump request and latched snapshot inputs
//   reg_addr_o/reg_rd_o/reg_data_i    register file read port (1-cycle latency)
//   mem_addr_o/mem_rd_o/mem_data_i/mem_dirty_i  data memory scan port (1-cycle latency)
//   tx_data_o/tx_start_o/tx_done_i    UART byte transmit handshake
//   busy_o/end_send_data_o            frame status
// The master modport is the environment (pipeline, memories, UART) view.
interface debug_dump_engine_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_CYCLES = 8,
  parameter int NB_REG    = 5,
  parameter int NB_ADDR   = 7
);
  logic                 start_i;
  logic [1:0]           mode_i;
  logic [NB_DATA-1:0]   pc_i;
  logic [NB_CYCLES-1:0] cycles_i;
  logic [NB_REG-1:0]    reg_addr_o;
  logic                 reg_rd_o;
  logic [NB_DATA-1:0]   reg_data_i;
  logic [NB_ADDR-1:0]   mem_addr_o;
  logic                 mem_rd_o;
  logic [NB_DATA-1:0]   mem_data_i;
  logic                 mem_dirty_i;
  logic [7:0]           tx_data_o;
  logic                 tx_start_o;
  logic                 tx_done_i;
  logic                 busy_o;
  logic                 end_send_data_o;

  modport slave (
    input  start_i, mode_i, pc_i, cycles_i, reg_data_i, mem_data_i, mem_dirty_i, tx_done_i,
    output reg_addr_o, reg_rd_o, mem_addr_o, mem_rd_o, tx_data_o, tx_start_o, busy_o,
           end_send_data_o
  );

  modport master (
    output start_i, mode_i, pc_i, cycles_i, reg_data_i, mem_data_i, mem_dirty_i, tx_done_i,
    input  reg_addr_o, reg_rd_o, mem_addr_o, mem_rd_o, tx_data_o, tx_start_o, busy_o,
           end_send_data_o
  );
endinterface

// File: rtl/debug_dump_engine.sv
// rtl/debug_dump_engine.sv - byte-framed register/memory debug dump to a UART transmitter
// Purpose: on start_i snapshots PC/cycles/mode, then streams
//   HEADER, PC, cycles, [registers], [dirty memory words + 00 terminator], [checksum]
//   one byte at a time over the tx_start_o/tx_done_i handshake, all fields MSB first.
// Ports:
//   clock_i  system clock
//   reset_i  synchronous active-low reset
//   bus      debug_dump_engine_if.slave (request, register/memory read ports, UART, status)
// Optional build macro: DEBUG_DUMP_CHECKSUM_EN appends an XOR of all bytes after HEADER.
module debug_dump_engine #(
  parameter int         NB_DATA   = 32,
  parameter int         NB_CYCLES = 8,
  parameter int         NB_REG    = 5,
  parameter int         N_REGS    = 32,
  parameter int         NB_ADDR   = 7,
  parameter int         MEM_DEPTH = 128,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input logic           clock_i,
  input logic           reset_i,
  debug_dump_engine_if.slave bus
);
  localparam int DATA_BYTES = NB_DATA / 8;
  localparam int CYC_BYTES  = NB_CYCLES / 8;
  localparam int ADDR_BYTES = (NB_ADDR + 7) / 8;
  localparam int RI_W       = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int MI_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int BI_W       = 8;

  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR, ST_PC, ST_CYC, ST_REG_REQ, ST_REG_CAP, ST_REG_DATA, ST_MEM_REQ,
    ST_MEM_CAP, ST_MEM_TAG, ST_MEM_ADDR, ST_MEM_DATA, ST_TERM, ST_CSUM, ST_WAIT, ST_DONE
  } state_t;

  state_t               state_q, state_d, ret_q, ret_d;
  logic [1:0]           mode_q;
  logic [NB_DATA-1:0]   pc_q, data_q, data_d;
  logic [NB_CYCLES-1:0] cyc_q;
  logic [RI_W-1:0]      reg_idx_q, reg_idx_d;
  logic [MI_W-1:0]      mem_idx_q, mem_idx_d;
  // Counts down to 0 within a multi-byte field so the shift below selects MSB first.
  logic [BI_W-1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 send;
  logic [7:0]           send_byte;
  state_t               next_field, end_state, after_cyc, after_regs;
  logic [7:0]           pc_byte, cyc_byte, data_byte, addr_byte;
  logic [ADDR_BYTES*8-1:0] addr_ext;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  function automatic logic [BI_W-1:0] first_idx(input state_t s);
    case (s)
      ST_PC, ST_REG_DATA, ST_MEM_DATA: first_idx = BI_W'(DATA_BYTES - 1);
      ST_CYC:                          first_idx = BI_W'(CYC_BYTES - 1);
      ST_MEM_ADDR:                     first_idx = BI_W'(ADDR_BYTES - 1);
      default:                         first_idx = '0;
    endcase
  endfunction

  assign addr_ext  = (ADDR_BYTES*8)'(mem_idx_q);
  assign pc_byte   = 8'(pc_q >> {byte_idx_q, 3'b000});
  assign cyc_byte  = 8'(cyc_q >> {byte_idx_q, 3'b000});
  assign data_byte = 8'(data_q >> {byte_idx_q, 3'b000});
  assign addr_byte = 8'(addr_ext >> {byte_idx_q, 3'b000});

`ifdef DEBUG_DUMP_CHECKSUM_EN
  assign end_state = ST_CSUM;
`else
  assign end_state = ST_DONE;
`endif
  // mode 00 full, 01 regs only, 10 mem only, 11 PC+cycles only
  assign after_regs = !mode_q[0] ? ST_MEM_REQ : end_state;
  assign after_cyc  = !mode_q[1] ? ST_REG_REQ : after_regs;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      mode_q     <= '0;
      pc_q       <= '0;
      cyc_q      <= '0;
      data_q     <= '0;
      reg_idx_q  <= '0;
      mem_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      data_q     <= data_d;
      reg_idx_q  <= reg_idx_d;
      mem_idx_q  <= mem_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      if (state_q == ST_IDLE && bus.start_i) begin
        mode_q <= bus.mode_i;
        pc_q   <= bus.pc_i;
        cyc_q  <= bus.cycles_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    data_d     = data_q;
    reg_idx_d  = reg_idx_q;
    mem_idx_d  = mem_idx_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    send       = 1'b0;
    send_byte  = 8'h00;
    next_field = state_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.start_i) begin
        state_d    = ST_HDR;
        reg_idx_d  = '0;
        mem_idx_d  = '0;
        byte_idx_d = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d     = '0;
`endif
      end
      ST_HDR:     begin send = 1'b1; send_byte = HEADER;    next_field = ST_PC;     end
      ST_PC:      begin send = 1'b1; send_byte = pc_byte;   next_field = ST_CYC;    end
      ST_CYC:     begin send = 1'b1; send_byte = cyc_byte;  next_field = after_cyc; end
      ST_REG_REQ: state_d = ST_REG_CAP;
      ST_REG_CAP: begin
        data_d     = bus.reg_data_i;
        byte_idx_d = first_idx(ST_REG_DATA);
        state_d    = ST_REG_DATA;
      end
      ST_REG_DATA: begin
        send      = 1'b1;
        send_byte = data_byte;
        if (reg_idx_q == RI_W'(N_REGS - 1)) begin
          next_field = after_regs;
        end else begin
          next_field = ST_REG_REQ;
          if (byte_idx_q == '0) reg_idx_d = reg_idx_q + 1'b1;
        end
      end
      ST_MEM_REQ: state_d = ST_MEM_CAP;
      ST_MEM_CAP: begin
        data_d = bus.mem_data_i;
        if (bus.mem_dirty_i) begin
          state_d = ST_MEM_TAG;
        end else if (mem_idx_q == MI_W'(MEM_DEPTH - 1)) begin
          state_d = ST_TERM;
        end else begin
          mem_idx_d = mem_idx_q + 1'b1;
          state_d   = ST_MEM_REQ;
        end
      end
      ST_MEM_TAG:  begin send = 1'b1; send_byte = 8'h01;     next_field = ST_MEM_ADDR; end
      ST_MEM_ADDR: begin send = 1'b1; send_byte = addr_byte; next_field = ST_MEM_DATA; end
      ST_MEM_DATA: begin
        send      = 1'b1;
        send_byte = data_byte;
        if (mem_idx_q == MI_W'(MEM_DEPTH - 1)) begin
          next_field = ST_TERM;
        end else begin
          next_field = ST_MEM_REQ;
          if (byte_idx_q == '0) mem_idx_d = mem_idx_q + 1'b1;
        end
      end
      ST_TERM: begin send = 1'b1; send_byte = 8'h00; next_field = end_state; end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      ST_CSUM: begin send = 1'b1; send_byte = csum_q; next_field = ST_DONE; end
`else
      ST_CSUM: state_d = ST_DONE;
`endif
      // tx_start_q is still high on the first WAIT cycle: a done there is not ours.
      ST_WAIT: if (bus.tx_done_i && !tx_start_q) state_d = ret_q;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (send) begin
      tx_data_d  = send_byte;
      tx_start_d = 1'b1;
      state_d    = ST_WAIT;
      if (byte_idx_q == '0) begin
        ret_d      = next_field;
        byte_idx_d = first_idx(next_field);
      end else begin
        ret_d      = state_q;
        byte_idx_d = byte_idx_q - 1'b1;
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      if (state_q != ST_HDR && state_q != ST_CSUM) csum_d = csum_q ^ send_byte;
`endif
    end
  end

  assign bus.reg_addr_o      = NB_REG'(reg_idx_q);
  assign bus.reg_rd_o        = (state_q == ST_REG_REQ);
  assign bus.mem_addr_o      = NB_ADDR'(mem_idx_q);
  assign bus.mem_rd_o        = (state_q == ST_MEM_REQ);
  assign bus.tx_data_o       = tx_data_q;
  assign bus.tx_start_o      = tx_start_q;
  assign bus.busy_o          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.end_send_data_o = (state_q == ST_DONE);
endmodule

// File: tb/tb_debug_dump_engine.sv
// tb/tb_debug_dump_engine.sv - self-checking bench for debug_dump_engine
module tb_debug_dump_engine;
  localparam int N_REGS    = 2;
  localparam int MEM_DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  debug_dump_engine_if #(.NB_DATA(32), .NB_CYCLES(8), .NB_REG(5), .NB_ADDR(7)) bus ();

  debug_dump_engine #(
    .NB_DATA(32), .NB_CYCLES(8), .NB_REG(5), .N_REGS(N_REGS),
    .NB_ADDR(7), .MEM_DEPTH(MEM_DEPTH), .HEADER(8'hA5)
  ) dut (
    .clock_i(clk),
    .reset_i(rstn),
    .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] regs [N_REGS];
  logic [31:0] mem  [MEM_DEPTH];
  logic        dirty[MEM_DEPTH];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  bit          model_on = 0;
  bit          have_byte = 0;
  logic [7:0]  last_byte = 8'h00;
  logic        prev_start = 1'b0;
  int          end_cnt = 0;
  int          uart_cnt = 0;
  bit          stray_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame built straight from the frame rules.
  task automatic build_frame(input logic [1:0] m, input logic [31:0] pc, input logic [7:0] cy);
    logic [7:0] body[$];
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) body.push_back(pc[8*k +: 8]);
    body.push_back(cy);
    if (m == 2'b00 || m == 2'b01)
      for (int r = 0; r < N_REGS; r++)
        for (int k = 3; k >= 0; k--) body.push_back(regs[r][8*k +: 8]);
    if (m == 2'b00 || m == 2'b10) begin
      for (int a = 0; a < MEM_DEPTH; a++)
        if (dirty[a]) begin
          body.push_back(8'h01);
          body.push_back(8'(a));
          for (int k = 3; k >= 0; k--) body.push_back(mem[a][8*k +: 8]);
        end
      body.push_back(8'h00);
    end
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      x ^= body[i];
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Register file and memory with 1-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    int ri, mi;
    ri = int'(bus.reg_addr_o);
    mi = int'(bus.mem_addr_o);
    bus.reg_data_i  <= (bus.reg_rd_o && ri < N_REGS) ? regs[ri] : 32'hBAD0_BAD0;
    bus.mem_data_i  <= (bus.mem_rd_o && mi < MEM_DEPTH) ? mem[mi] : 32'hBAD1_BAD1;
    bus.mem_dirty_i <= (bus.mem_rd_o && mi < MEM_DEPTH) ? dirty[mi] : 1'b0;
  end

  // UART: tx_done_i pulses 3 cycles after each tx_start_o; stray pulses on request.
  always @(negedge clk) begin
    bus.tx_done_i = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus.tx_done_i = 1'b1;
    end
    if (bus.tx_start_o) uart_cnt = 3;
    if (stray_req) begin
      bus.tx_done_i = 1'b1;
      stray_req = 0;
    end
  end

  // Compare process: every transmitted byte against the model, hold and pulse width rules.
  always @(negedge clk) begin
    if (model_on) begin
      if (bus.tx_start_o) begin
        check("tx_start_one_cycle", prev_start, 1'b0);
        obs_q.push_back(bus.tx_data_o);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_byte: got %02h expected no byte", bus.tx_data_o);
        end else begin
          check("tx_byte", bus.tx_data_o, exp_q.pop_front());
        end
        last_byte = bus.tx_data_o;
        have_byte = 1;
      end else if (bus.busy_o && have_byte) begin
        check("tx_data_hold", bus.tx_data_o, last_byte);
      end
      if (bus.end_send_data_o) end_cnt++;
    end
    prev_start = bus.tx_start_o;
  end

  task automatic pulse_start(input logic [1:0] m, input logic [31:0] pc, input logic [7:0] cy);
    @(negedge clk);
    #1;
    bus.mode_i = m; bus.pc_i = pc; bus.cycles_i = cy; bus.start_i = 1'b1;
    @(negedge clk);
    #1;
    bus.start_i = 1'b0; bus.mode_i = ~m; bus.pc_i = ~pc; bus.cycles_i = ~cy;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [31:0] pc, input logic [7:0] cy,
                           input int repulse_at, input bit start_on_done);
    bit done, repulsed, busy_seen;
    done = 0; repulsed = 0; busy_seen = 0;
    build_frame(m, pc, cy);
    obs_q.delete();
    end_cnt = 0;
    have_byte = 0;
    model_on = 1;
    pulse_start(m, pc, cy);
    check("busy_after_start", bus.busy_o, 1'b1);
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (repulse_at > 0 && !repulsed && obs_q.size() >= repulse_at) begin
        bus.start_i = 1'b1; bus.mode_i = 2'b00;
        @(negedge clk);
        #1;
        bus.start_i = 1'b0;
        repulsed = 1;
      end
      if (bus.end_send_data_o) begin
        done = 1;
        check("busy_low_on_done", bus.busy_o, 1'b0);
        if (start_on_done) bus.start_i = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no end pulse expected one within 4000 cycles");
    end
    if (start_on_done) begin
      @(negedge clk);
      #1;
      bus.start_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.busy_o) busy_seen = 1;
      end
      check("no_restart_from_done", busy_seen, 1'b0);
    end else begin
      repeat (5) @(negedge clk);
    end
    check("end_pulses", end_cnt, 1);
    check("model_drained", exp_q.size(), 0);
    check("busy_idle", bus.busy_o, 1'b0);
  endtask

  initial begin
    logic [7:0] lit1[6]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h07};
    logic [7:0] lit2[8]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] lit3[7]  = '{8'h01, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    int csum_len;
    int ends_in_reset;
    bit reached;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    csum_len = 1;
`else
    csum_len = 0;
`endif
    rstn = 1'b0;
    bus.start_i = 1'b0; bus.mode_i = 2'b00; bus.pc_i = '0; bus.cycles_i = '0;
    for (int r = 0; r < N_REGS; r++) regs[r] = 32'h0;
    for (int a = 0; a < MEM_DEPTH; a++) begin mem[a] = 32'hC0DE_0000 + a; dirty[a] = 1'b0; end

    repeat (3) @(negedge clk);
    check("rst_tx_start", bus.tx_start_o, 1'b0);
    check("rst_tx_data", bus.tx_data_o, 8'h00);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_end", bus.end_send_data_o, 1'b0);
    check("rst_reg_rd", bus.reg_rd_o, 1'b0);
    check("rst_mem_rd", bus.mem_rd_o, 1'b0);
    rstn = 1'b1;

    // Mode 11: PC and cycles only.
    run_frame(2'b11, 32'h0000_0040, 8'h07, 0, 0);
    check("m11_len", obs_q.size(), 6 + csum_len);
    for (int i = 0; i < 6; i++) check("m11_lit", obs_q[i], lit1[i]);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    check("m11_csum", obs_q[6], 8'h47);
`endif

    // Mode 01: registers only.
    regs[0] = 32'h0000_0001;
    regs[1] = 32'hDEAD_BEEF;
    mem[2]  = 32'h1234_5678;
    dirty[2] = 1'b1;
    run_frame(2'b01, 32'h0000_1000, 8'h10, 0, 0);
    check("m01_len", obs_q.size(), 14 + csum_len);
    for (int i = 0; i < 8; i++) check("m01_lit", obs_q[6+i], lit2[i]);

    // Mode 10: memory only, single dirty word at address 2.
    run_frame(2'b10, 32'hFFFF_FFFC, 8'hFF, 0, 0);
    check("m10_len", obs_q.size(), 13 + csum_len);
    for (int i = 0; i < 7; i++) check("m10_lit", obs_q[6+i], lit3[i]);

    // Mode 00 with all memory clean: registers then a lone terminator.
    dirty[2] = 1'b0;
    run_frame(2'b00, 32'h8000_0001, 8'h80, 0, 0);
    check("m00_clean_len", obs_q.size(), 15 + csum_len);
    check("m00_clean_term", obs_q[14], 8'h00);

    // Mode 00 with first and last memory words dirty.
    dirty[0] = 1'b1;
    dirty[3] = 1'b1;
    run_frame(2'b00, 32'h1357_9BDF, 8'h5A, 0, 0);
    check("m00_dirty_len", obs_q.size(), 27 + csum_len);

    // Reset during register byte 3 of the frame aborts it.
    build_frame(2'b00, 32'h0000_0010, 8'h01);
    obs_q.delete();
    have_byte = 0;
    model_on = 1;
    pulse_start(2'b00, 32'h0000_0010, 8'h01);
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= 9) reached = 1;
    end
    check("abort_reached_reg_byte3", reached, 1'b1);
    rstn = 1'b0;
    model_on = 0;
    exp_q.delete();
    @(negedge clk);
    check("abort_tx_start", bus.tx_start_o, 1'b0);
    check("abort_busy", bus.busy_o, 1'b0);
    ends_in_reset = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.end_send_data_o) ends_in_reset++;
      if (i == 2) rstn = 1'b1;
      @(negedge clk);
    end
    check("abort_no_end", ends_in_reset, 0);
    run_frame(2'b11, 32'hCAFE_F00D, 8'h3C, 0, 0);
    check("after_abort_hdr", obs_q[0], 8'hA5);

    // Stray tx_done_i while idle, then start re-pulsed mid-frame and on the DONE cycle.
    obs_q.delete();
    exp_q.delete();
    model_on = 1;
    @(negedge clk);
    stray_req = 1;
    repeat (10) @(negedge clk);
    check("stray_no_busy", bus.busy_o, 1'b0);
    check("stray_no_bytes", obs_q.size(), 0);
    run_frame(2'b01, 32'h0000_0040, 8'h07, 3, 1);
    check("repulse_len", obs_q.size(), 14 + csum_len);

    model_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
